// File: rtl/sram_pkg.sv
// Shared constants for the SRAM controller: FSM state encodings and access-counter sizing.
// Also holds the saturating-increment helper used by both counters.
package sram_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/sram_sp_array.sv
// Behavioural single-port RAM with per-byte write enables and a registered read port.
// Kept deliberately macro-like so a vendor SRAM can replace it without touching the controller.
module sram_sp_array #(
    parameter int MEM_DEPTH  = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // rdata only moves on a read, so writes never disturb the last read result.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DATA_WIDTH/8; b++) begin
                    if (wbe[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// SRAM controller behind the AHB slave: zero-init sweep FSM, bus/sweep request muxing,
// out-of-range guard and saturating read/write counters.
module sram_mem_ctrl
    import sram_pkg::*;
#(
    parameter int                  MEM_DEPTH  = 1024,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_BITS  = 10,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                    hclk_i,
    input  logic                    hrst_i,
    input  logic                    mem_en_i,
    input  logic                    mem_we_i,
    input  logic [DATA_WIDTH/8-1:0] mem_wbe_i,
    input  logic [ADDR_BITS-1:0]    mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_ready_o,
    input  logic                    init_req_i,
    output logic                    init_busy_o,
    output logic [CNT_W-1:0]        rd_cnt_o,
    output logic [CNT_W-1:0]        wr_cnt_o,
    output logic [0:0]              state_o
);

    localparam logic [ADDR_BITS-1:0] LAST_PTR  = ADDR_BITS'(MEM_DEPTH - 1);
    localparam logic [ADDR_BITS:0]   DEPTH_EXT = (ADDR_BITS+1)'(MEM_DEPTH);

    logic [0:0]            state;
    logic [ADDR_BITS-1:0]  ptr;
    logic                  rd_zero;
    logic [CNT_W-1:0]      rd_cnt;
    logic [CNT_W-1:0]      wr_cnt;

    logic                    run;
    logic                    in_range;
    logic                    acc_rd;
    logic                    acc_wr;
    logic                    arr_en;
    logic                    arr_we;
    logic [DATA_WIDTH/8-1:0] arr_wbe;
    logic [ADDR_BITS-1:0]    arr_addr;
    logic [DATA_WIDTH-1:0]   arr_wdata;
    logic [DATA_WIDTH-1:0]   arr_rdata;

    always_comb begin
        run      = (state == ST_RUN);
        in_range = ({1'b0, mem_addr_i} < DEPTH_EXT);
        acc_rd   = run && mem_en_i && !mem_we_i;
        acc_wr   = run && mem_en_i && mem_we_i;

        if (!run) begin
            arr_en    = !hrst_i;
            arr_we    = 1'b1;
            arr_wbe   = '1;
            arr_addr  = ptr;
            arr_wdata = INIT_VAL;
        end else begin
            arr_en    = mem_en_i && in_range && !hrst_i;
            arr_we    = mem_we_i;
            arr_wbe   = mem_wbe_i;
            arr_addr  = mem_addr_i;
            arr_wdata = mem_wdata_i;
        end
    end

    sram_sp_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk  (hclk_i),
        .en   (arr_en),
        .we   (arr_we),
        .wbe  (arr_wbe),
        .addr (arr_addr),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            state   <= ST_INIT;
            ptr     <= '0;
            rd_zero <= 1'b1;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (ptr == LAST_PTR) begin
                        state <= ST_RUN;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    // A read in this same cycle is still serviced; the sweep starts next cycle.
                    if (init_req_i) begin
                        state <= ST_INIT;
                        ptr   <= '0;
                    end
                end
            endcase

            if (acc_rd) begin
                rd_zero <= !in_range;
                rd_cnt  <= sat_inc(rd_cnt);
            end
            if (acc_wr) begin
                wr_cnt <= sat_inc(wr_cnt);
            end
        end
    end

    // The macro's read register is not reset, so rd_zero masks it after reset and for out-of-range reads.
    assign mem_rdata_o = rd_zero ? '0 : arr_rdata;
    assign mem_ready_o = (state == ST_RUN);
    assign init_busy_o = (state == ST_INIT);
    assign rd_cnt_o    = rd_cnt;
    assign wr_cnt_o    = wr_cnt;
    assign state_o     = state;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: array model, read-expectation queue and counter totals.
// Uses a non-power-of-2 depth so out-of-range addresses are reachable.
module tb_sram_mem_ctrl;

    localparam int DEPTH = 1000;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam logic [DW-1:0] INIT_V = '0;

    logic          hclk;
    logic          hrst;
    logic          mem_en;
    logic          mem_we;
    logic [DW/8-1:0] mem_wbe;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          init_req;
    logic          init_busy;
    logic [15:0]   rd_cnt;
    logic [15:0]   wr_cnt;
    logic [0:0]    state_dbg;

    sram_mem_ctrl #(
        .MEM_DEPTH (DEPTH),
        .DATA_WIDTH(DW),
        .ADDR_BITS (AW),
        .INIT_VAL  (INIT_V)
    ) dut (
        .hclk_i     (hclk),
        .hrst_i     (hrst),
        .mem_en_i   (mem_en),
        .mem_we_i   (mem_we),
        .mem_wbe_i  (mem_wbe),
        .mem_addr_i (mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata),
        .mem_ready_o(mem_ready),
        .init_req_i (init_req),
        .init_busy_o(init_busy),
        .rd_cnt_o   (rd_cnt),
        .wr_cnt_o   (wr_cnt),
        .state_o    (state_dbg)
    );

    // Clock / reset
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference model
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            model_rd;
    int            model_wr;
    bit            model_run;
    logic [DW-1:0] last_rdata;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [15:0] sat16(input int total);
        return (total > 65535) ? 16'hFFFF : 16'(total);
    endfunction

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic model_clear_mem();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_V;
    endtask

    task automatic check_counts(input string name);
        n_checks++;
        if (rd_cnt !== sat16(model_rd)) begin
            n_errors++;
            $display("FAIL %s rd_cnt: got %h expected %h", name, rd_cnt, sat16(model_rd));
        end
        n_checks++;
        if (wr_cnt !== sat16(model_wr)) begin
            n_errors++;
            $display("FAIL %s wr_cnt: got %h expected %h", name, wr_cnt, sat16(model_wr));
        end
    endtask

    // Driver tasks
    task automatic bus_write(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = AW'(a);
        mem_wdata = d;
        mem_wbe   = be;
        if (model_run) begin
            model_wr++;
            if (a < DEPTH) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
        tick();
        mem_en = 1'b0;
    endtask

    task automatic bus_read(input int a, input string name);
        logic [DW-1:0] exp;
        mem_en   = 1'b1;
        mem_we   = 1'b0;
        mem_addr = AW'(a);
        if (model_run) begin
            model_rd++;
            exp_q.push_back((a < DEPTH) ? model_mem[a] : '0);
        end
        tick();
        mem_en = 1'b0;
        if (model_run && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            last_rdata = exp;
        end else begin
            exp = last_rdata;
        end
        n_checks++;
        if (mem_rdata !== exp) begin
            n_errors++;
            $display("FAIL %s rdata @%0d: got %h expected %h", name, a, mem_rdata, exp);
        end
    endtask

    task automatic apply_reset();
        hrst = 1'b1;
        tick();
        hrst = 1'b0;
        model_run  = 1'b0;
        model_rd   = 0;
        model_wr   = 0;
        last_rdata = '0;
        exp_q.delete();
    endtask

    // Counts low-ready samples (already_low seen so far) until ready rises; bounded.
    task automatic wait_sweep(input int already_low, input string name);
        int n;
        n = already_low;
        while (!mem_ready && n < 5000) begin
            tick();
            if (!mem_ready) n++;
        end
        n_checks++;
        if (n !== DEPTH || mem_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s sweep length: got %0d low cycles ready=%b expected %0d", name, n, mem_ready, DEPTH);
        end
        n_checks++;
        if (init_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s busy after sweep: got %b expected 0", name, init_busy);
        end
        model_run = 1'b1;
        model_clear_mem();
    endtask

    // Scenarios
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (mem_ready !== 1'b0 || init_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset flags: got ready=%b busy=%b expected ready=0 busy=1", mem_ready, init_busy);
        end
        n_checks++;
        if (mem_rdata !== '0) begin
            n_errors++;
            $display("FAIL reset rdata: got %h expected 0", mem_rdata);
        end
        check_counts("reset");
        wait_sweep(1, "reset");
        bus_read(5, "reset_read5");
    endtask

    task automatic test_byte_write();
        bus_write(3, 32'hDEADBEEF, 4'hF);
        bus_write(3, 32'h000000AA, 4'b0001);
        bus_read(3, "byte_write");
        bus_write(3, 32'h11223344, 4'b1010);
        bus_write(4, 32'hCAFEF00D, 4'b0000);
        bus_read(3, "byte_write_1010");
        bus_read(4, "byte_write_wbe0");
        check_counts("byte_write");
    endtask

    task automatic test_back_to_back();
        bus_write(7, 32'h12345678, 4'hF);
        bus_read(7, "raw_next_cycle");
        check_counts("raw");
    endtask

    task automatic test_rdata_hold();
        logic [DW-1:0] held;
        bus_write(20, 32'hA5A5_0F0F, 4'hF);
        bus_read(20, "hold_read");
        held = last_rdata;
        bus_write(20, 32'h0, 4'hF);
        tick();
        tick();
        n_checks++;
        if (mem_rdata !== held) begin
            n_errors++;
            $display("FAIL rdata_hold: got %h expected %h", mem_rdata, held);
        end
    endtask

    task automatic test_out_of_range();
        bus_write(DEPTH, 32'hFFFF_FFFF, 4'hF);
        bus_write(1023, 32'hFFFF_FFFF, 4'hF);
        bus_read(DEPTH - 1, "oor_last_valid");
        bus_read(1023, "oor_read_zero");
        bus_read(DEPTH, "oor_read_depth");
        check_counts("oor");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int a;
            a = (($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 4, 1023)) : int'($urandom_range(0, 31)));
            case ($urandom_range(0, 2))
                0: bus_write(a, $urandom, 4'($urandom_range(0, 15)));
                1: bus_read(a, "random");
                default: tick();
            endcase
        end
        check_counts("random");
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 99; i++) tick();
        bus_write(9, 32'h1, 4'hF);
        apply_reset();
        n_checks++;
        if (mem_rdata !== '0 || mem_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset state: got rdata=%h ready=%b expected 0/0", mem_rdata, mem_ready);
        end
        check_counts("mid_reset");
        wait_sweep(1, "mid_reset");
    endtask

    task automatic test_init_req();
        int low;
        int saved_rd;
        int saved_wr;
        bus_write(9, 32'h55, 4'hF);
        bus_write(11, 32'h77, 4'hF);
        // Read issued in the same cycle as the init request is still serviced.
        init_req = 1'b1;
        bus_read(11, "init_req_same_cycle");
        init_req = 1'b0;
        model_run = 1'b0;
        saved_rd = model_rd;
        saved_wr = model_wr;
        n_checks++;
        if (mem_ready !== 1'b0 || init_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL init_req flags: got ready=%b busy=%b expected ready=0 busy=1", mem_ready, init_busy);
        end
        low = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) init_req = 1'b1;
            if (i[0]) bus_write(9, 32'hFFFF_FFFF, 4'hF);
            else bus_read(9, "sweep_drop_hold");
            init_req = 1'b0;
            if (!mem_ready) low++;
        end
        wait_sweep(low, "init_req");
        n_checks++;
        if (model_rd !== saved_rd || model_wr !== saved_wr) begin
            n_errors++;
            $display("FAIL init_req model totals: got %0d/%0d expected %0d/%0d", model_rd, model_wr, saved_rd, saved_wr);
        end
        check_counts("init_req_retain");
        bus_read(9, "after_sweep_9");
        bus_read(11, "after_sweep_11");
        check_counts("init_req_after");
    endtask

    task automatic test_saturate();
        int n;
        n = 16'hFFFE - model_wr;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wbe   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < n; i++) tick();
        mem_en = 1'b0;
        model_wr += n;
        check_counts("sat_fffe");
        for (int i = 0; i < 3; i++) bus_write(0, 32'h0, 4'h0);
        n_checks++;
        if (wr_cnt !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL saturate wr_cnt: got %h expected ffff", wr_cnt);
        end
        check_counts("sat_ffff");
        bus_read(0, "sat_read0");
    endtask

    initial begin
        hrst      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wbe   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        init_req  = 1'b0;
        model_run = 1'b0;
        model_rd  = 0;
        model_wr  = 0;
        last_rdata = '0;
        model_clear_mem();
        tick();

        test_reset();
        test_byte_write();
        test_back_to_back();
        test_rdata_hold();
        test_out_of_range();
        test_random();
        test_mid_reset();
        test_byte_write();
        test_init_req();
        test_saturate();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
